// File: rtl/uart_dbg_bridge_pkg.sv
// Shared constants and state encodings for the UART debug bridge.
package uart_dbg_bridge_pkg;

    localparam logic [31:0] DEFAULT_BAUD_DIV     = 32'h1B8;
    localparam logic [15:0] DEFAULT_TIMEOUT_BITS = 16'd20;

    localparam logic [7:0] CMD_WR  = 8'hA5;
    localparam logic [7:0] CMD_RD  = 8'hA6;
    localparam logic [7:0] RSP_OK  = 8'h5A;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0,
        P_ADDR = 3'd1,
        P_DATA = 3'd2,
        P_BUS  = 3'd3,
        P_RESP = 3'd4
    } parser_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronises rx_pin, validates the start bit at half period,
// samples data and stop bits mid-bit. rx_valid / rx_err pulse in the stop-sample cycle.
//
// state   | meaning
// R_IDLE  | waiting for a falling edge
// R_START | counting to mid start bit; high there means a glitch
// R_DATA  | sampling 8 data bits, bit 0 first
// R_STOP  | sampling stop bit; low means framing error
module uart_byte_rx
    import uart_dbg_bridge_pkg::*;
#(
    parameter logic [31:0] BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam logic [15:0] BIT_END  = BAUD_DIV[15:0];
    localparam logic [15:0] HALF_END = {1'b0, BAUD_DIV[15:1]};

    rx_state_t   state, state_n;
    logic        rx_s1, rx_s2, rx_d;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_d    <= 1'b1;
            state   <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            rx_s1   <= rx_pin;
            rx_s2   <= rx_s1;
            rx_d    <= rx_s2;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        case (state)
            R_IDLE: begin
                if (rx_d && !rx_s2) begin
                    cnt_n   = '0;
                    state_n = R_START;
                end
            end
            R_START: begin
                if (cnt == HALF_END) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s2 ? R_IDLE : R_DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            R_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n     = '0;
                    shift_n   = {rx_s2, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = R_STOP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            R_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n    = '0;
                    rx_valid = rx_s2;
                    rx_err   = !rx_s2;
                    state_n  = R_IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = R_IDLE;
        endcase
    end

    assign rx_byte = shift;

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART-to-bus debug bridge: serial read/write frames become single-word bus
// requests; the response is shifted back out on tx_pin.
//
// state  | meaning
// P_IDLE | waiting for command byte
// P_ADDR | collecting 4 address bytes, LSB first
// P_DATA | collecting 4 write-data bytes, LSB first
// P_BUS  | req_o high until ack_i
// P_RESP | shifting out 1 or 4 response bytes back-to-back
module uart_dbg_bridge
    import uart_dbg_bridge_pkg::*;
#(
    parameter logic [31:0] BAUD_DIV     = DEFAULT_BAUD_DIV,
    parameter logic [15:0] TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i,
    output logic        busy_o
);

    localparam logic [15:0] BIT_END = BAUD_DIV[15:0];

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx_pin   (rx_pin),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    parser_state_t state, state_n;
    logic          we_q, we_n;
    logic [31:0]   addr_q, addr_n;
    logic [31:0]   wdata_q, wdata_n;
    logic [31:0]   rsp_q, rsp_n;
    logic [1:0]    idx_q, idx_n;
    logic [1:0]    last_q, last_n;
    logic [15:0]   bit_cnt, bit_cnt_n;
    logic [15:0]   tmo_cnt, tmo_cnt_n;
    logic [3:0]    tx_bit, tx_bit_n;
    logic          tx_q, tx_n;
    logic [7:0]    tx_byte;
    logic          bit_end;
    logic          tx_done;

    // bit_cnt is the bit-period prescaler for both the timeout and the TX shifter
    assign bit_end = (bit_cnt == BIT_END);
    assign tx_byte = rsp_q[{idx_q, 3'b000} +: 8];
    assign tx_done = (state == P_RESP) && bit_end && (tx_bit == 4'd9) && (idx_q == last_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= P_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            tx_bit  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rsp_q   <= rsp_n;
            idx_q   <= idx_n;
            last_q  <= last_n;
            bit_cnt <= bit_cnt_n;
            tmo_cnt <= tmo_cnt_n;
            tx_bit  <= tx_bit_n;
            tx_q    <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        we_n      = we_q;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        rsp_n     = rsp_q;
        idx_n     = idx_q;
        last_n    = last_q;
        bit_cnt_n = bit_cnt;
        tmo_cnt_n = tmo_cnt;
        tx_bit_n  = tx_bit;
        tx_n      = tx_q;
        case (state)
            P_IDLE: begin
                if (rx_valid) begin
                    idx_n     = 2'd0;
                    bit_cnt_n = '0;
                    tmo_cnt_n = '0;
                    if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
                        we_n    = (rx_byte == CMD_WR);
                        state_n = P_ADDR;
                    end else begin
                        rsp_n    = {24'h0, RSP_ERR};
                        last_n   = 2'd0;
                        tx_bit_n = 4'd0;
                        tx_n     = 1'b0;
                        state_n  = P_RESP;
                    end
                end
            end
            P_ADDR, P_DATA: begin
                if (rx_err) begin
                    state_n = P_IDLE;
                end else if (rx_valid) begin
                    bit_cnt_n = '0;
                    tmo_cnt_n = '0;
                    idx_n     = idx_q + 2'd1;
                    if (state == P_ADDR) addr_n[{idx_q, 3'b000} +: 8] = rx_byte;
                    else                 wdata_n[{idx_q, 3'b000} +: 8] = rx_byte;
                    if (idx_q == 2'd3) begin
                        state_n = (state == P_ADDR && we_q) ? P_DATA : P_BUS;
                    end
                end else if (tmo_cnt == TIMEOUT_BITS) begin
                    state_n = P_IDLE;
                end else if (bit_end) begin
                    bit_cnt_n = '0;
                    if (tmo_cnt != 16'hFFFF) tmo_cnt_n = tmo_cnt + 16'd1;
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            P_BUS: begin
                if (ack_i) begin
                    idx_n     = 2'd0;
                    bit_cnt_n = '0;
                    tx_bit_n  = 4'd0;
                    tx_n      = 1'b0;
                    state_n   = P_RESP;
                    if (we_q) begin
                        rsp_n  = {24'h0, RSP_OK};
                        last_n = 2'd0;
                    end else begin
                        rsp_n  = data_i;
                        last_n = 2'd3;
                    end
                end
            end
            P_RESP: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    if (tx_bit == 4'd9) begin
                        if (idx_q == last_q) begin
                            tx_n    = 1'b1;
                            state_n = P_IDLE;
                        end else begin
                            idx_n    = idx_q + 2'd1;
                            tx_bit_n = 4'd0;
                            tx_n     = 1'b0;
                        end
                    end else begin
                        // tx_bit is the bit now ending; drive the one after it
                        tx_bit_n = tx_bit + 4'd1;
                        tx_n     = (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            default: state_n = P_IDLE;
        endcase
        addr_n[1:0] = 2'b00;
    end

    assign tx_pin = tx_q;
    assign req_o  = (state == P_BUS);
    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = wdata_q;
    assign busy_o = (state != P_IDLE) && !tx_done;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed plus randomized bench for uart_dbg_bridge against a frame-level
// reference model; serial lines are driven and decoded at bit level.
module tb_uart_dbg_bridge;

    localparam logic [31:0] BAUD = 32'd15;
    localparam int          P    = 16;
    localparam int          TMO  = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_pin;
    logic        tx_pin;
    logic        req_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        ack_i;
    logic        busy_o;

    uart_dbg_bridge #(.BAUD_DIV(BAUD), .TIMEOUT_BITS(16'(TMO))) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_pin (rx_pin),
        .tx_pin (tx_pin),
        .req_o  (req_o),
        .we_o   (we_o),
        .addr_o (addr_o),
        .data_o (data_o),
        .data_i (data_i),
        .ack_i  (ack_i),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          ack_delay = 3;
    int          ack_cyc = 0;
    int          req_hold_err = 0;
    int          tx_stop_err = 0;
    logic [31:0] rd_data = 32'h0;
    logic [7:0]  mon_byte;

    logic [7:0]  frame[$];
    logic [7:0]  exp_rsp[$];
    logic [7:0]  tx_bytes[$];
    int          tx_start[$];
    logic        bus_we[$];
    logic [31:0] bus_addr[$];
    logic [31:0] bus_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    // bus target: records each request, acks after ack_delay cycles
    initial begin
        ack_i  = 1'b0;
        data_i = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && req_o === 1'b1) begin
                bus_we.push_back(we_o);
                bus_addr.push_back(addr_o);
                bus_data.push_back(data_o);
                for (int i = 0; i < ack_delay && req_o === 1'b1; i++) @(negedge clk);
                if (req_o === 1'b1) begin
                    ack_i   = 1'b1;
                    data_i  = rd_data;
                    ack_cyc = cyc;
                    @(negedge clk);
                    ack_i  = 1'b0;
                    data_i = 32'hBAD0_BAD0;
                    if (req_o !== 1'b0) req_hold_err++;
                end
            end
        end
    end

    // serial decoder on tx_pin
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx_pin === 1'b0) begin
                tx_start.push_back(cyc);
                repeat (P / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (P) @(negedge clk);
                    mon_byte[i] = tx_pin;
                end
                repeat (P) @(negedge clk);
                if (tx_pin !== 1'b1) tx_stop_err++;
                tx_bytes.push_back(mon_byte);
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_pin = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (P) @(negedge clk);
        end
        rx_pin = stop;
        repeat (P) @(negedge clk);
        rx_pin = 1'b1;
    endtask

    task automatic send_frame(input int bad_idx);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], i != bad_idx);
            if (i == bad_idx) break;
        end
    endtask

    task automatic clear_logs();
        tx_bytes.delete();
        tx_start.delete();
        bus_we.delete();
        bus_addr.delete();
        bus_data.delete();
        req_hold_err = 0;
        tx_stop_err  = 0;
    endtask

    // Frame-level model: bytes before a corrupted stop bit are delivered, the rest never sent.
    task automatic model(input int bad_idx, output bit m_req, output logic m_we,
                         output logic [31:0] m_addr, output logic [31:0] m_data, output bit m_busy);
        int n;
        int need;
        logic [7:0] c;
        n = (bad_idx >= 0) ? bad_idx : frame.size();
        exp_rsp.delete();
        m_req = 0; m_we = 0; m_addr = 0; m_data = 0; m_busy = 0;
        if (n == 0) return;
        c = frame[0];
        if (c == 8'hA5 || c == 8'hA6) begin
            need = (c == 8'hA5) ? 9 : 5;
            if (n >= need) begin
                m_req  = 1;
                m_busy = 1;
                m_we   = (c == 8'hA5);
                m_addr = {frame[4], frame[3], frame[2], frame[1]} & 32'hFFFF_FFFC;
                if (m_we) begin
                    m_data = {frame[8], frame[7], frame[6], frame[5]};
                    exp_rsp.push_back(8'h5A);
                end else begin
                    for (int i = 0; i < 4; i++) exp_rsp.push_back(8'((rd_data >> (8 * i)) & 32'hFF));
                end
            end else begin
                m_busy = (bad_idx < 0);
            end
        end else begin
            exp_rsp.push_back(8'hEE);
            m_busy = 1;
        end
    endtask

    task automatic run_case(input string tag, input int bad_idx);
        bit          m_req, m_busy;
        logic        m_we;
        logic [31:0] m_addr, m_data;
        int          k;
        clear_logs();
        model(bad_idx, m_req, m_we, m_addr, m_data, m_busy);
        send_frame(bad_idx);
        check({tag, "/busy_after_frame"}, 32'(busy_o), 32'(m_busy));
        k = 0;
        while (busy_o !== 1'b0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "/busy_released"}, 32'(busy_o), 32'd0);
        if (m_busy && !m_req && exp_rsp.size() == 0)
            check({tag, "/timeout_len"}, 32'(k >= 300 && k <= 330), 32'd1);
        repeat (3 * P) @(negedge clk);
        check({tag, "/req_count"}, bus_we.size(), 32'(m_req));
        if (m_req && bus_we.size() > 0) begin
            check({tag, "/we"}, 32'(bus_we[0]), 32'(m_we));
            check({tag, "/addr"}, bus_addr[0], m_addr);
            if (m_we) check({tag, "/wdata"}, bus_data[0], m_data);
            check({tag, "/req_drop"}, req_hold_err, 32'd0);
        end
        check({tag, "/rsp_count"}, tx_bytes.size(), exp_rsp.size());
        for (int i = 0; i < exp_rsp.size() && i < tx_bytes.size(); i++)
            check($sformatf("%s/rsp%0d", tag, i), 32'(tx_bytes[i]), 32'(exp_rsp[i]));
        if (tx_bytes.size() > 0) check({tag, "/stop_bits"}, tx_stop_err, 32'd0);
        if (m_req && tx_start.size() > 0)
            check({tag, "/tx_latency"}, tx_start[0] - ack_cyc, 32'd1);
        for (int i = 1; i < tx_start.size(); i++)
            check($sformatf("%s/gap%0d", tag, i), tx_start[i] - tx_start[i-1], 32'(10 * P));
        check({tag, "/tx_idle"}, 32'(tx_pin), 32'd1);
    endtask

    task automatic build_rand(input bit wr);
        logic [31:0] a, d;
        a = $urandom;
        d = $urandom;
        rd_data = $urandom;
        frame.delete();
        frame.push_back(wr ? 8'hA5 : 8'hA6);
        for (int i = 0; i < 4; i++) frame.push_back(8'(a >> (8 * i)));
        if (wr) for (int i = 0; i < 4; i++) frame.push_back(8'(d >> (8 * i)));
    endtask

    initial begin
        int k;
        rst    = 1'b0;
        rx_pin = 1'b1;
        repeat (4) @(negedge clk);
        check("reset/tx_pin", 32'(tx_pin), 32'd1);
        check("reset/req_o",  32'(req_o),  32'd0);
        check("reset/we_o",   32'(we_o),   32'd0);
        check("reset/addr_o", addr_o,      32'd0);
        check("reset/data_o", data_o,      32'd0);
        check("reset/busy_o", 32'(busy_o), 32'd0);
        rst = 1'b1;
        repeat (P) @(negedge clk);

        frame = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ack_delay = 3;
        run_case("wr_dir", -1);

        frame = '{8'hA6, 8'h07, 8'h01, 8'h00, 8'h00};
        rd_data = 32'h1234_5678;
        ack_delay = 2;
        run_case("rd_dir", -1);

        frame = '{8'h33};
        run_case("unknown", -1);

        frame = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_case("bad_stop", 2);

        frame = '{8'hA5, 8'h01, 8'h02, 8'h03};
        run_case("timeout", -1);
        build_rand(1'b0);
        ack_delay = 0;
        run_case("after_timeout", -1);

        rx_pin = 1'b0;
        repeat (int'(BAUD) / 4) @(negedge clk);
        rx_pin = 1'b1;
        repeat (12 * P) @(negedge clk);
        frame.delete();
        run_case("glitch", -1);
        build_rand(1'b1);
        ack_delay = 1;
        run_case("after_glitch", -1);

        // reset while a request is waiting for ack
        build_rand(1'b1);
        ack_delay = 100000;
        clear_logs();
        send_frame(-1);
        check("rst_bus/req_pending", 32'(req_o), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_bus/req_o", 32'(req_o), 32'd0);
        check("rst_bus/addr_o", addr_o, 32'd0);
        rst = 1'b1;
        ack_delay = 2;
        repeat (12 * P) @(negedge clk);

        // reset during the second response byte
        build_rand(1'b0);
        clear_logs();
        send_frame(-1);
        k = 0;
        while (tx_start.size() < 2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("rst_rsp/second_byte", 32'(tx_start.size() >= 2), 32'd1);
        repeat (3 * P) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rsp/tx_pin", 32'(tx_pin), 32'd1);
        check("rst_rsp/req_o",  32'(req_o),  32'd0);
        check("rst_rsp/busy_o", 32'(busy_o), 32'd0);
        rst = 1'b1;
        repeat (12 * P) @(negedge clk);
        build_rand(1'b0);
        run_case("after_rst", -1);

        for (int t = 0; t < 6; t++) begin
            build_rand(1'($urandom_range(0, 1)));
            ack_delay = $urandom_range(0, 5);
            run_case($sformatf("rand%0d", t), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
